memory_stage_ctrl: RTL and testbench
====================================

// Module: memory_stage_ctrl
// PURPOSE
//  Parametrised data-memory stage for the Y86 pipeline (M stage). Decodes icode
//  into read/write, accesses an internal word array with configurable depth and
//  wait states, and flags address errors. Sits between execute and writeback,
//  with valid/ready handshakes on both sides so multi-cycle accesses stall cleanly.
// PARAMETERS
//  DATA_W       64   data width of memory words, valA/valE/valM
//  DEPTH        128  number of words in the array (power of 2, >=2)
//  WAIT_CYCLES  0    extra cycles per memory access (0..15); non-memory ops never wait
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  M_valid      in   1       M-stage inputs valid
//  M_ready      out  1       stage accepts inputs this cycle
//  M_icode      in   4       instruction code
//  M_valA       in   DATA_W  store data / pop-ret address
//  M_valE       in   DATA_W  ALU result / store-load address
//  M_dstE       in   4       passed through
//  M_dstM       in   4       passed through
//  M_Cnd        in   1       passed through
//  m_valid      out  1       W-side outputs valid
//  m_ready      in   1       writeback accepts outputs
//  m_icode      out  4       registered icode
//  m_valM       out  DATA_W  read data (0 for non-read ops and on error)
//  m_valE       out  DATA_W  registered M_valE
//  m_dstE       out  4       registered dstE
//  m_dstM       out  4       registered dstM
//  m_Cnd        out  1       registered Cnd
//  m_stat       out  3       1=AOK 2=HLT 3=ADR 4=INS
// BEHAVIOUR
//  - One clock (clock); reset is synchronous, active-high, dominates all events.
//  - Reset: state=IDLE; m_valid=0, m_valM=0, m_valE=0, m_icode=0, m_dstE=m_dstM=4'hF,
//    m_Cnd=0, m_stat=1. Memory contents NOT cleared. Reset mid-access abandons it;
//    a write not yet committed is never performed.
//  - M_ready = (state==IDLE) && !reset. Accept = M_valid && M_ready.
//  - Op decode: write @valE<-valA for icode 4,8,A; read @valE for 5; read @valA for
//    9,B; icodes 0-3,6,7 no access; icode >B -> INS, no access; icode 0 -> HLT.
//  - FSM IDLE -> (accept, access op, WAIT_CYCLES>0) WAIT -> RESP; IDLE -> (accept,
//    otherwise) RESP. WAIT counts WAIT_CYCLES cycles then RESP. RESP -> IDLE on
//    m_valid && m_ready; holds all outputs stable while m_ready=0.
//  - Latency accept->m_valid: 1 cycle (no access or WAIT_CYCLES=0), 1+WAIT_CYCLES otherwise.
//    No back-to-back accept: next accept earliest cycle after output handshake.
//  - Write commits and read data captures on the edge entering RESP; read uses array
//    contents as of that edge (a write in the same op class cannot coincide).
//  - Address index = addr (word index). addr >= DEPTH (any upper bit set) -> m_stat=ADR,
//    write suppressed, m_valM=0.
//  - Status priority: INS > HLT > ADR > AOK. Pass-through fields registered on accept.
// CONFIGURATION
//  MEM_BYTE_ADDR_EN defined: addresses are byte addresses; index = addr>>3;
//    addr[2:0]!=0 -> ADR (no access); range check on addr>>3 vs DEPTH.
//  Not defined: addresses are word indices, no alignment check (current pipeline).
// TESTING
//  1 Reset held 2 cycles -> m_valid=0, m_stat=1, M_ready=1 on first cycle after release.
//  2 WAIT_CYCLES=0: rmmovq(4) valE=5 valA=64'h1234, then mrmovq(5) valE=5 ->
//    m_valM=64'h1234, m_stat=1, each m_valid 1 cycle after accept.
//  3 WAIT_CYCLES=3: pushq(A) valE=10 valA=64'hAB; M_ready=0 for 4 cycles; then popq(B)
//    valA=10 -> m_valM=64'hAB after 4 cycles.
//  4 mrmovq valE=128 (DEPTH=128) -> m_stat=3, m_valM=0; rmmovq valE=200 -> no array change.
//  5 Output stall: m_ready=0 for 5 cycles in RESP -> outputs stable, M_ready=0; icode 4'hC
//    -> m_stat=4; icode 0 -> m_stat=2.
//  6 Reset asserted during WAIT of a write to addr 7 -> subsequent read addr 7 returns
//    old value. With MEM_BYTE_ADDR_EN: read addr 12 -> ADR; addr 16 -> word 2.

Source files
------------

// File: rtl/memory_stage_ctrl.sv
// Y86 pipeline memory (M) stage: decodes icode into read/write,
// accesses an internal word array with optional wait states and
// flags address/instruction errors. Valid/ready on both sides.
//
// Ports:
//   clock, reset        rising-edge clock, sync active-high reset
//   M_valid / M_ready   execute-side handshake
//   M_icode, M_valA, M_valE, M_dstE, M_dstM, M_Cnd   execute inputs
//   m_valid / m_ready   writeback-side handshake
//   m_icode, m_valM, m_valE, m_dstE, m_dstM, m_Cnd, m_stat  outputs
//
// Build option: MEM_BYTE_ADDR_EN selects byte addressing
// (index = addr>>3, misaligned address -> ADR). Word indexing otherwise.
module memory_stage_ctrl #(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              M_valid,
    output logic              M_ready,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic              M_Cnd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [3:0]        m_icode,
    output logic [DATA_W-1:0] m_valM,
    output logic [DATA_W-1:0] m_valE,
    output logic [3:0]        m_dstE,
    output logic [3:0]        m_dstM,
    output logic              m_Cnd,
    output logic [2:0]        m_stat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WLOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              enter_resp;
    logic              accept;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [3:0]        icode_q;
    logic [DATA_W-1:0] valA_q;
    logic [DATA_W-1:0] valE_q;
    logic [DATA_W-1:0] valM_q;
    logic [3:0]        dstE_q;
    logic [3:0]        dstM_q;
    logic              cnd_q;
    logic [2:0]        stat_q;

    logic [3:0]        cur_icode;
    logic [DATA_W-1:0] cur_valA;
    logic [DATA_W-1:0] cur_valE;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] widx;
    logic [AW-1:0]     idx;
    logic              is_wr;
    logic              is_rd;
    logic              adr_err;
    logic [2:0]        stat;

    assign M_ready = (state_q == IDLE) && !reset;
    assign accept  = M_valid && M_ready;

    // While idle the op comes straight from the inputs (zero-wait
    // access happens on the accept edge); afterwards from the latched copy.
    always_comb begin
        cur_icode = (state_q == IDLE) ? M_icode : icode_q;
        cur_valA  = (state_q == IDLE) ? M_valA  : valA_q;
        cur_valE  = (state_q == IDLE) ? M_valE  : valE_q;
    end

    always_comb begin
        is_wr = (cur_icode == 4'h4) || (cur_icode == 4'h8) ||
                (cur_icode == 4'hA);
        is_rd = (cur_icode == 4'h5) || (cur_icode == 4'h9) ||
                (cur_icode == 4'hB);
        // ret and popq read from the stack pointer held in valA
        addr  = ((cur_icode == 4'h9) || (cur_icode == 4'hB)) ?
                cur_valA : cur_valE;
`ifdef MEM_BYTE_ADDR_EN
        widx    = addr >> 3;
        adr_err = (is_wr || is_rd) &&
                  ((addr[2:0] != 3'd0) || ((widx >> AW) != '0));
`else
        widx    = addr;
        adr_err = (is_wr || is_rd) && ((widx >> AW) != '0);
`endif
        idx = widx[AW-1:0];
        if (cur_icode > 4'hB)
            stat = S_INS;
        else if (cur_icode == 4'h0)
            stat = S_HLT;
        else if (adr_err)
            stat = S_ADR;
        else
            stat = S_AOK;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((is_wr || is_rd) && (WAIT_CYCLES > 0)) begin
                        state_d = WAIT;
                        cnt_d   = WLOAD;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (m_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Array is never cleared; reset blocks a pending commit.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && is_wr && !adr_err)
            mem[idx] <= cur_valA;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            icode_q <= 4'h0;
            valA_q  <= '0;
            valE_q  <= '0;
            valM_q  <= '0;
            dstE_q  <= 4'hF;
            dstM_q  <= 4'hF;
            cnd_q   <= 1'b0;
            stat_q  <= S_AOK;
        end else begin
            if (accept) begin
                icode_q <= M_icode;
                valA_q  <= M_valA;
                valE_q  <= M_valE;
                dstE_q  <= M_dstE;
                dstM_q  <= M_dstM;
                cnd_q   <= M_Cnd;
                stat_q  <= stat;
            end
            if (enter_resp)
                valM_q <= (is_rd && !adr_err) ? mem[idx] : '0;
        end
    end

    assign m_valid = (state_q == RESP);
    assign m_icode = icode_q;
    assign m_valM  = valM_q;
    assign m_valE  = valE_q;
    assign m_dstE  = dstE_q;
    assign m_dstM  = dstM_q;
    assign m_Cnd   = cnd_q;
    assign m_stat  = stat_q;

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Bench for memory_stage_ctrl: a zero-wait and a three-wait instance,
// table-driven ops plus hand-written stall and reset-abort sequences.
module tb_memory_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        mv  [2];
    logic        mr  [2];
    logic [3:0]  ic  [2];
    logic [63:0] va  [2];
    logic [63:0] ve  [2];
    logic [3:0]  de  [2];
    logic [3:0]  dm  [2];
    logic        cn  [2];
    logic        rdy [2];
    logic        ov  [2];
    logic [3:0]  oic [2];
    logic [63:0] ovm [2];
    logic [63:0] ove [2];
    logic [3:0]  ode [2];
    logic [3:0]  odm [2];
    logic        ocn [2];
    logic [2:0]  ost [2];

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valM;
        logic [63:0] valE;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic        cnd;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [3:0]  ic;
        logic [63:0] a;
        logic [63:0] e;
        logic [2:0]  xs;
        logic [63:0] xm;
    } vec_t;

    vec_t tbl [17];

    memory_stage_ctrl #(.DATA_W(64), .DEPTH(128), .WAIT_CYCLES(0)) u0 (
        .clock(clk), .reset(rst),
        .M_valid(mv[0]), .M_ready(rdy[0]), .M_icode(ic[0]),
        .M_valA(va[0]), .M_valE(ve[0]), .M_dstE(de[0]),
        .M_dstM(dm[0]), .M_Cnd(cn[0]),
        .m_valid(ov[0]), .m_ready(mr[0]), .m_icode(oic[0]),
        .m_valM(ovm[0]), .m_valE(ove[0]), .m_dstE(ode[0]),
        .m_dstM(odm[0]), .m_Cnd(ocn[0]), .m_stat(ost[0])
    );

    memory_stage_ctrl #(.DATA_W(64), .DEPTH(128), .WAIT_CYCLES(3)) u3 (
        .clock(clk), .reset(rst),
        .M_valid(mv[1]), .M_ready(rdy[1]), .M_icode(ic[1]),
        .M_valA(va[1]), .M_valE(ve[1]), .M_dstE(de[1]),
        .M_dstM(dm[1]), .M_Cnd(cn[1]),
        .m_valid(ov[1]), .m_ready(mr[1]), .m_icode(oic[1]),
        .m_valM(ovm[1]), .m_valE(ove[1]), .m_dstE(ode[1]),
        .m_dstM(odm[1]), .m_Cnd(ocn[1]), .m_stat(ost[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] A(input logic [63:0] w);
`ifdef MEM_BYTE_ADDR_EN
        return w << 3;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_op(input int d, input logic [3:0] icode,
                          input logic [63:0] a, input logic [63:0] e,
                          input logic [3:0] dste, input logic [3:0] dstm,
                          input logic cnd, input logic [2:0] xs,
                          input logic [63:0] xm, input int xlat,
                          input int stall);
        int n;
        int lat;
        int busy;
        exp_t x;
        logic [63:0] hold_vm;
        logic [2:0]  hold_st;
        sb.push_back('{icode, xs, xm, e, dste, dstm, cnd});
        @(negedge clk);
        n = 0;
        while (!rdy[d] && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_op", 64'(rdy[d]), 64'd1);
        ic[d] = icode; va[d] = a; ve[d] = e;
        de[d] = dste; dm[d] = dstm; cn[d] = cnd;
        mv[d] = 1'b1;
        mr[d] = (stall == 0);
        @(posedge clk);
        #1;
        mv[d] = 1'b0;
        ic[d] = 4'($urandom); va[d] = {$urandom, $urandom};
        ve[d] = {$urandom, $urandom};
        de[d] = 4'($urandom); dm[d] = 4'($urandom); cn[d] = ~cnd;
        lat = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rdy[d]) busy++;
        end while (!ov[d] && lat < 64);
        x = sb.pop_front();
        chk("latency", 64'(lat), 64'(xlat));
        chk("busy_cycles", 64'(busy), 64'(xlat));
        chk("m_stat", 64'(ost[d]), 64'(x.stat));
        chk("m_valM", ovm[d], x.valM);
        chk("m_valE", ove[d], x.valE);
        chk("m_icode", 64'(oic[d]), 64'(x.icode));
        chk("m_dstE", 64'(ode[d]), 64'(x.dstE));
        chk("m_dstM", 64'(odm[d]), 64'(x.dstM));
        chk("m_Cnd", 64'(ocn[d]), 64'(x.cnd));
        hold_vm = ovm[d];
        hold_st = ost[d];
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_valid", 64'(ov[d]), 64'd1);
            chk("stall_ready", 64'(rdy[d]), 64'd0);
            chk("stall_valM", ovm[d], hold_vm);
            chk("stall_stat", 64'(ost[d]), 64'(hold_st));
        end
        mr[d] = 1'b1;
        @(negedge clk);
        chk("valid_drops", 64'(ov[d]), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{4'h4, 64'h1234, A(5),   3'd1, 64'h0};
        tbl[1]  = '{4'h5, 64'h0,    A(5),   3'd1, 64'h1234};
        tbl[2]  = '{4'h8, 64'h55,   A(20),  3'd1, 64'h0};
        tbl[3]  = '{4'h9, A(20),    64'h9,  3'd1, 64'h55};
        tbl[4]  = '{4'hA, 64'hAA,   A(3),   3'd1, 64'h0};
        tbl[5]  = '{4'hB, A(3),     64'h8,  3'd1, 64'hAA};
        tbl[6]  = '{4'h6, 64'h1,    64'h77, 3'd1, 64'h0};
        tbl[7]  = '{4'h3, 64'h2,    64'h33, 3'd1, 64'h0};
        tbl[8]  = '{4'hC, 64'h3,    A(5),   3'd4, 64'h0};
        tbl[9]  = '{4'h0, 64'h4,    A(5),   3'd2, 64'h0};
        tbl[10] = '{4'h5, 64'h0,    A(128), 3'd3, 64'h0};
        tbl[11] = '{4'h4, 64'h1111, A(72),  3'd1, 64'h0};
        tbl[12] = '{4'h4, 64'h2222, A(200), 3'd3, 64'h0};
        tbl[13] = '{4'h5, 64'h0,    A(72),  3'd1, 64'h1111};
        tbl[14] = '{4'hF, 64'h0,    A(200), 3'd4, 64'h0};
        tbl[15] = '{4'h9, A(64'h4000_0000_0000_0005), 64'h0, 3'd3, 64'h0};
        tbl[16] = '{4'h5, 64'h0,    A(5),   3'd1, 64'h1234};

        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; mr[d] = 1'b1; ic[d] = 4'h0;
            va[d] = '0; ve[d] = '0; de[d] = '0; dm[d] = '0; cn[d] = 1'b0;
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", 64'(ov[d]), 64'd0);
            chk("rst_stat", 64'(ost[d]), 64'd1);
            chk("rst_ready", 64'(rdy[d]), 64'd1);
            chk("rst_dstE", 64'(ode[d]), 64'hF);
            chk("rst_dstM", 64'(odm[d]), 64'hF);
            chk("rst_valM", ovm[d], 64'h0);
            chk("rst_valE", ove[d], 64'h0);
            chk("rst_icode", 64'(oic[d]), 64'h0);
        end

        for (int i = 0; i < 17; i++)
            run_op(0, tbl[i].ic, tbl[i].a, tbl[i].e, 4'(i), 4'(15 - i),
                   i[0], tbl[i].xs, tbl[i].xm, 1, 0);

        // output stall held five cycles
        run_op(0, 4'h6, 64'h5, 64'hBEEF, 4'h2, 4'h3, 1'b1,
               3'd1, 64'h0, 1, 5);
        run_op(0, 4'h5, 64'h0, A(5), 4'hF, 4'h0, 1'b0,
               3'd1, 64'h1234, 1, 5);

        // three wait states on memory ops only
        run_op(1, 4'hA, 64'hAB, A(10), 4'h4, 4'hF, 1'b0,
               3'd1, 64'h0, 4, 0);
        run_op(1, 4'hB, A(10), 64'h0, 4'h4, 4'h1, 1'b1,
               3'd1, 64'hAB, 4, 0);
        run_op(1, 4'h6, 64'h0, 64'h42, 4'h1, 4'hF, 1'b0,
               3'd1, 64'h0, 1, 0);
        run_op(1, 4'h5, 64'h0, A(300), 4'hF, 4'h2, 1'b0,
               3'd3, 64'h0, 4, 2);

        // reset during WAIT aborts the pending write
        run_op(1, 4'h4, 64'hCAFE, A(7), 4'hF, 4'hF, 1'b0,
               3'd1, 64'h0, 4, 0);
        @(negedge clk);
        begin
            int n = 0;
            while (!rdy[1] && n < 64) begin
                @(negedge clk);
                n++;
            end
        end
        ic[1] = 4'h4; va[1] = 64'hDEAD; ve[1] = A(7);
        mv[1] = 1'b1;
        @(posedge clk);
        #1;
        mv[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wait", 64'(ov[1]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_valid", 64'(ov[1]), 64'd0);
        chk("abort_ready", 64'(rdy[1]), 64'd1);
        chk("abort_dstE", 64'(ode[1]), 64'hF);
        chk("abort_stat", 64'(ost[1]), 64'd1);
        run_op(1, 4'h5, 64'h0, A(7), 4'h0, 4'h6, 1'b1,
               3'd1, 64'hCAFE, 4, 0);

`ifdef MEM_BYTE_ADDR_EN
        run_op(0, 4'h5, 64'h0, 64'd12, 4'h0, 4'h1, 1'b0,
               3'd3, 64'h0, 1, 0);
        run_op(0, 4'h4, 64'h77, 64'd16, 4'h0, 4'h1, 1'b0,
               3'd1, 64'h0, 1, 0);
        run_op(0, 4'h9, 64'd16, 64'h0, 4'h0, 4'h1, 1'b0,
               3'd1, 64'h77, 1, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
